// File: rtl/btn_hex_entry_pkg.sv
// Shared types, default timing and helpers for the button hex entry stage.
// Imported by the debounce sub-module and the top level.
package btn_hex_entry_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PRESS_CHK = 2'd1,
        ST_HELD      = 2'd2,
        ST_REL_CHK   = 2'd3
    } btn_state_e;

    localparam int          DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int          DEF_REPEAT_DELAY    = 50_000_000;
    localparam int          DEF_REPEAT_PERIOD   = 20_000_000;
    localparam logic [15:0] DEF_RESET_VALUE     = 16'hABCD;

    // Counter width wide enough for the largest timing constant.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

    // One hex step, wrapping mod 16; dec selects decrement.
    function automatic logic [3:0] step_nibble(input logic [3:0] v,
                                               input logic dec);
        return dec ? v - 4'd1 : v + 4'd1;
    endfunction

endpackage

// File: rtl/btn_hex_entry_debounce.sv
// One button: 2-FF synchroniser, debounce FSM and auto-repeat timer.
// pulse is a one-cycle step strobe; level is the debounced held state.
module btn_hex_entry_debounce
    import btn_hex_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic pulse
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY,
                                  REPEAT_PERIOD);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] RD_LAST =
        CW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
    localparam logic [CW-1:0] RP_LAST =
        CW'((REPEAT_PERIOD > 1) ? REPEAT_PERIOD - 1 : 0);
    localparam bit REP_EN = (REPEAT_DELAY != 0);

    logic          sync1_q, sync1_d;
    logic          s_q, s_d;
    btn_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] rcnt_q, rcnt_d;
    logic          rep_q, rep_d;
    logic          level_q, level_d;
    logic          pulse_d;

    // State registers, all cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            s_q     <= 1'b0;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rcnt_q  <= '0;
            rep_q   <= 1'b0;
            level_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            s_q     <= s_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rcnt_q  <= rcnt_d;
            rep_q   <= rep_d;
            level_q <= level_d;
        end
    end

    // Debounce FSM; rep_q selects delay vs period for the repeat timer.
    always_comb begin
        sync1_d = btn_raw;
        s_d     = sync1_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        rcnt_d  = rcnt_q;
        rep_d   = rep_q;
        level_d = level_q;
        pulse_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (s_q) begin
                    state_d = ST_PRESS_CHK;
                    cnt_d   = '0;
                end
            end
            ST_PRESS_CHK: begin
                if (!s_q) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == DB_LAST) begin
                    state_d = ST_HELD;
                    pulse_d = 1'b1;
                    level_d = 1'b1;
                    rcnt_d  = '0;
                    rep_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_HELD: begin
                if (!s_q) begin
                    state_d = ST_REL_CHK;
                    cnt_d   = '0;
                end else if (REP_EN) begin
                    if (rcnt_q == (rep_q ? RP_LAST : RD_LAST)) begin
                        pulse_d = 1'b1;
                        rcnt_d  = '0;
                        rep_d   = 1'b1;
                    end else begin
                        rcnt_d = rcnt_q + CW'(1);
                    end
                end
            end
            ST_REL_CHK: begin
                if (s_q) begin
                    state_d = ST_HELD;
                    rcnt_d  = '0;
                    rep_d   = 1'b0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = ST_IDLE;
                    level_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign level = level_q;
    // No step may escape in a cycle where reset is asserted.
    assign pulse = pulse_d & ~rst;

endmodule

// File: rtl/btn_hex_entry.sv
// Four debounced buttons each stepping one hex nibble of num.
// btn[0] drives the top nibble, btn[3] the bottom one.
module btn_hex_entry
    import btn_hex_entry_pkg::*;
#(
    parameter int          DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int          REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int          REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter logic [15:0] RESET_VALUE     = DEF_RESET_VALUE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  btn_raw,
    input  logic        dir,
    output logic [15:0] num,
    output logic [3:0]  btn_level,
    output logic [3:0]  btn_pulse
);

    logic [15:0] num_q, num_d;

    for (genvar g = 0; g < 4; g++) begin : g_btn
        btn_hex_entry_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_db (
            .clk    (clk),
            .rst    (rst),
            .btn_raw(btn_raw[g]),
            .level  (btn_level[g]),
            .pulse  (btn_pulse[g])
        );
    end

    // Each pulsing button steps its own nibble; no carry between nibbles.
    always_comb begin
        num_d = num_q;
        for (int i = 0; i < 4; i++) begin
            if (btn_pulse[i]) begin
                num_d[4*(3-i) +: 4] = step_nibble(num_q[4*(3-i) +: 4], dir);
            end
        end
    end

    // Value register.
    always_ff @(posedge clk) begin
        if (rst) num_q <= RESET_VALUE;
        else     num_q <= num_d;
    end

    assign num = num_q;

endmodule

// File: tb/tb_btn_hex_entry.sv
// Bench for btn_hex_entry with short timing constants.
// Table vectors for reset/press/release, hand sequences for the rest.
module tb_btn_hex_entry;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  btn_raw;
    logic        dir;
    logic [15:0] num;
    logic [3:0]  btn_level;
    logic [3:0]  btn_pulse;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    btn_hex_entry #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (3),
        .RESET_VALUE    (16'hABCD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_raw  (btn_raw),
        .dir      (dir),
        .num      (num),
        .btn_level(btn_level),
        .btn_pulse(btn_pulse)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  raw;
        logic        dir;
        logic [15:0] num;
        logic [3:0]  lvl;
        logic [3:0]  pls;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic [3:0] raw,
                                input logic d, input logic [15:0] n,
                                input logic [3:0] l, input logic [3:0] p);
        vec_t v;
        v.rst = r; v.raw = raw; v.dir = d;
        v.num = n; v.lvl = l; v.pls = p;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // Steps until btn_pulse[idx] is seen; n is the cycle count (30 = timeout).
    task automatic wait_pulse(input int idx, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!btn_pulse[idx] && n < 30);
    endtask

    // Holds one button until cnt step pulses have been seen, then releases.
    task automatic press_n(input int idx, input int cnt, input logic d);
        int got;
        got = 0;
        dir = d;
        btn_raw[idx] = 1'b1;
        for (int k = 0; k < 300 && got < cnt; k++) begin
            step();
            if (btn_pulse[idx]) got++;
        end
        btn_raw[idx] = 1'b0;
        chk($sformatf("press_n btn%0d count", idx), got, cnt);
        idle(12);
    endtask

    initial begin
        int n;
        int miss;
        int np;
        logic [3:0] seen_p;
        logic [3:0] seen_l;
        logic       exp_p;

        rst = 1'b1;
        btn_raw = 4'h0;
        dir = 1'b0;

        // reset, clean press of btn0, release
        vecs.push_back(mk(1, 4'h0, 0, 16'hABCD, 4'h0, 4'h0));
        vecs.push_back(mk(1, 4'h0, 0, 16'hABCD, 4'h0, 4'h0));
        vecs.push_back(mk(0, 4'h0, 0, 16'hABCD, 4'h0, 4'h0));
        for (int k = 0; k < 5; k++)
            vecs.push_back(mk(0, 4'h1, 0, 16'hABCD, 4'h0, 4'h0));
        vecs.push_back(mk(0, 4'h1, 0, 16'hABCD, 4'h0, 4'h1));
        vecs.push_back(mk(0, 4'h1, 0, 16'hBBCD, 4'h1, 4'h0));
        vecs.push_back(mk(0, 4'h1, 0, 16'hBBCD, 4'h1, 4'h0));
        for (int k = 0; k < 6; k++)
            vecs.push_back(mk(0, 4'h0, 0, 16'hBBCD, 4'h1, 4'h0));
        vecs.push_back(mk(0, 4'h0, 0, 16'hBBCD, 4'h0, 4'h0));
        vecs.push_back(mk(0, 4'h0, 0, 16'hBBCD, 4'h0, 4'h0));

        foreach (vecs[i]) begin
            rst = vecs[i].rst;
            btn_raw = vecs[i].raw;
            dir = vecs[i].dir;
            step();
            chk($sformatf("vec%0d num", i), num, vecs[i].num);
            chk($sformatf("vec%0d level", i), btn_level, vecs[i].lvl);
            chk($sformatf("vec%0d pulse", i), btn_pulse, vecs[i].pls);
        end

        // glitch train on btn3, then a clean decrement press
        seen_p = 4'h0;
        seen_l = 4'h0;
        for (int k = 0; k < 12; k++) begin
            btn_raw[3] = (k < 4) ? ((k % 2) == 0) : 1'b0;
            step();
            seen_p |= btn_pulse;
            seen_l |= btn_level;
        end
        chk("glitch pulse", seen_p, 4'h0);
        chk("glitch level", seen_l, 4'h0);
        chk("glitch num", num, 16'hBBCD);

        dir = 1'b1;
        btn_raw[3] = 1'b1;
        wait_pulse(3, n);
        chk("dec latency", n, 6);
        chk("dec pulse", btn_pulse, 4'h8);
        step();
        chk("dec num", num, 16'hBBCC);
        chk("dec level", btn_level, 4'h8);
        btn_raw[3] = 1'b0;
        dir = 1'b0;
        idle(12);
        chk("dec released", btn_level, 4'h0);

        // auto-repeat on btn1
        btn_raw[1] = 1'b1;
        wait_pulse(1, n);
        chk("rpt latency", n, 6);
        miss = 0;
        np = 0;
        for (int off = 1; off <= 25; off++) begin
            step();
            exp_p = (off >= 10) && (((off - 10) % 3) == 0);
            if (btn_pulse[1] !== exp_p) miss++;
            if (btn_pulse[1]) np++;
            if (off == 1) chk("rpt first step", num, 16'hBCCC);
        end
        btn_raw[1] = 1'b0;
        chk("rpt misplaced", miss, 0);
        chk("rpt count", np, 6);
        step();
        chk("rpt num", num, 16'hB2CC);
        idle(12);

        // bring all nibbles to F, then press all together
        press_n(0, 4, 1'b0);
        press_n(1, 3, 1'b1);
        press_n(2, 3, 1'b0);
        press_n(3, 3, 1'b0);
        chk("all F", num, 16'hFFFF);
        dir = 1'b0;
        btn_raw = 4'hF;
        wait_pulse(0, n);
        chk("all latency", n, 6);
        chk("all pulse", btn_pulse, 4'hF);
        step();
        chk("all wrap", num, 16'h0000);
        chk("all single", btn_pulse, 4'h0);
        btn_raw = 4'h0;
        idle(12);

        // reset while btn2 is held
        btn_raw[2] = 1'b1;
        wait_pulse(2, n);
        chk("hold latency", n, 6);
        step();
        step();
        chk("hold num", num, 16'h0010);
        rst = 1'b1;
        step();
        chk("rst num", num, 16'hABCD);
        chk("rst level", btn_level, 4'h0);
        chk("rst pulse", btn_pulse, 4'h0);
        step();
        chk("rst pulse2", btn_pulse, 4'h0);
        rst = 1'b0;
        wait_pulse(2, n);
        chk("post-rst latency", n, 6);
        step();
        chk("post-rst num", num, 16'hABDD);
        chk("post-rst level", btn_level, 4'h4);
        btn_raw = 4'h0;
        idle(12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
